// File: rtl/watch_scan_mux.sv
// Debug-probe selector: picks one of CH packed probe channels (manual or auto-scan),
// with a snapshot bank, freeze-to-snapshot view and a differs-from-snapshot flag.
module watch_scan_mux #(
    parameter int unsigned CH    = 16,
    parameter int unsigned W     = 32,
    parameter int unsigned SEL_W = 4,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   probe_bus,
    input  logic              auto_mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              snap,
    input  logic              freeze,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_changed,
    output logic              out_valid
);

    localparam int unsigned     CntW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

    logic [W-1:0]     live   [CH];
    logic [W-1:0]     snap_q [CH];
    logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
    logic [CntW-1:0]  dwell_q, dwell_d;
    logic             freeze_q;
    logic             capture;
    logic             ch_ok;
    logic [SEL_W-1:0] ch_idx;
    logic [W-1:0]     live_sel, snap_sel;

    for (genvar g = 0; g < CH; g++) begin : g_unpack
        assign live[g] = probe_bus[g*W +: W];
    end

    always_comb begin
        cur_ch_d = cur_ch_q;
        dwell_d  = dwell_q;
        if (!auto_mode) begin
            cur_ch_d = sel_in;
            dwell_d  = '0;
        end else if (dwell_q == CntLast) begin
            dwell_d  = '0;
            // Last channel and any out-of-range index both wrap to channel 0.
            cur_ch_d = (32'(cur_ch_q) >= CH - 1) ? '0 : cur_ch_q + 1'b1;
        end else begin
            dwell_d  = dwell_q + 1'b1;
        end
    end

    // Outputs are computed from the channel being loaded this edge, so a new
    // selection is visible after a single cycle.
    always_comb begin
        ch_ok    = (32'(cur_ch_d) < CH);
        ch_idx   = ch_ok ? cur_ch_d : '0;
        live_sel = live[ch_idx];
        snap_sel = snap_q[ch_idx];
        capture  = (snap && !freeze) || (freeze && !freeze_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_ch_q <= '0;
            dwell_q  <= '0;
            freeze_q <= 1'b0;
        end else begin
            cur_ch_q <= cur_ch_d;
            dwell_q  <= dwell_d;
            freeze_q <= freeze;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) snap_q[i] <= '0;
        end else if (capture) begin
            for (int i = 0; i < CH; i++) snap_q[i] <= live[i];
        end
    end

    // Data and change flag read the pre-capture snapshot on a capture edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data    <= '0;
            out_ch      <= '0;
            out_changed <= 1'b0;
            out_valid   <= 1'b1;
        end else begin
            out_ch      <= cur_ch_d;
            out_valid   <= ch_ok;
            out_data    <= ch_ok ? (freeze ? snap_sel : live_sel) : '0;
            out_changed <= ch_ok && (live_sel != snap_sel);
        end
    end

endmodule

// File: tb/tb_watch_scan_mux.sv
// Directed bench for watch_scan_mux: CH=12, W=16, SEL_W=4, DWELL=4.
module tb_watch_scan_mux;

    localparam int unsigned CH    = 12;
    localparam int unsigned W     = 16;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned DWELL = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*W-1:0]   probe_bus;
    logic              auto_mode;
    logic [SEL_W-1:0]  sel_in;
    logic              snap;
    logic              freeze;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_changed;
    logic              out_valid;

    logic [W-1:0] pv [CH];
    int n_checks = 0;
    int n_fail   = 0;

    watch_scan_mux #(
        .CH    (CH),
        .W     (W),
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .probe_bus   (probe_bus),
        .auto_mode   (auto_mode),
        .sel_in      (sel_in),
        .snap        (snap),
        .freeze      (freeze),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_changed (out_changed),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        probe_bus = '0;
        for (int i = 0; i < CH; i++) probe_bus[i*W +: W] = pv[i];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        auto_mode = 1'b0;
        sel_in    = '0;
        snap      = 1'b0;
        freeze    = 1'b0;
        for (int i = 0; i < CH; i++) pv[i] = W'($urandom);

        // 1. Reset
        #12;
        check_eq("rst_data", 32'(out_data), 32'h0);
        check_eq("rst_ch", 32'(out_ch), 32'h0);
        check_eq("rst_changed", 32'(out_changed), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h1);
        rst    = 1'b1;
        pv[3]  = 16'h3333;
        sel_in = 4'd3;
        step();
        check_eq("sel3_ch", 32'(out_ch), 32'd3);
        check_eq("sel3_data", 32'(out_data), 32'h3333);
        check_eq("sel3_changed", 32'(out_changed), 32'h1);

        // 2. Manual follow and out-of-range index
        sel_in = 4'd5;
        pv[5]  = 16'h1234;
        step();
        check_eq("sel5_data_a", 32'(out_data), 32'h1234);
        pv[5] = 16'hBEEF;
        check_eq("sel5_hold", 32'(out_data), 32'h1234);
        step();
        check_eq("sel5_data_b", 32'(out_data), 32'hBEEF);
        sel_in = 4'd13;
        step();
        check_eq("oor_valid", 32'(out_valid), 32'h0);
        check_eq("oor_data", 32'(out_data), 32'h0);
        check_eq("oor_ch", 32'(out_ch), 32'd13);
        check_eq("oor_changed", 32'(out_changed), 32'h0);

        // 3. Auto scan with wrap, then manual takeover mid-dwell
        sel_in = 4'd0;
        step();
        auto_mode = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_eq($sformatf("scan_k%0d", k), 32'(out_ch), 32'((k / 4) % 12));
        end
        auto_mode = 1'b0;
        sel_in    = 4'd7;
        step();
        check_eq("manual_takeover", 32'(out_ch), 32'd7);

        // 4. Snapshot, change flag, freeze view, snap ignored while frozen
        pv[2]  = 16'hAAAA;
        sel_in = 4'd2;
        step();
        check_eq("pre_snap_changed", 32'(out_changed), 32'h1);
        snap = 1'b1;
        step();
        check_eq("snap_edge_changed", 32'(out_changed), 32'h1);
        snap = 1'b0;
        step();
        check_eq("post_snap_changed", 32'(out_changed), 32'h0);
        pv[2] = 16'h5555;
        step();
        check_eq("diff_changed", 32'(out_changed), 32'h1);
        check_eq("diff_data", 32'(out_data), 32'h5555);
        freeze = 1'b1;
        step();
        check_eq("freeze_edge_data", 32'(out_data), 32'hAAAA);
        check_eq("freeze_edge_changed", 32'(out_changed), 32'h1);
        step();
        check_eq("frozen_data", 32'(out_data), 32'h5555);
        check_eq("frozen_changed", 32'(out_changed), 32'h0);
        pv[2] = 16'h1111;
        step();
        check_eq("frozen_live_moves", 32'(out_data), 32'h5555);
        snap = 1'b1;
        step();
        check_eq("frozen_snap_data", 32'(out_data), 32'h5555);
        snap = 1'b0;
        step();
        check_eq("frozen_no_capture", 32'(out_data), 32'h5555);
        check_eq("frozen_no_capture_chg", 32'(out_changed), 32'h1);
        freeze = 1'b0;
        step();
        check_eq("unfreeze_data", 32'(out_data), 32'h1111);

        // 5. freeze rising edge together with snap: one capture of static probes
        for (int i = 0; i < CH; i++) pv[i] = W'($urandom) | 16'h0001;
        pv[2] = 16'h2222;
        step();
        check_eq("pre_fz_changed", 32'(out_changed), 32'h1);
        freeze = 1'b1;
        snap   = 1'b1;
        step();
        snap = 1'b0;
        for (int i = 0; i < CH; i++) begin
            sel_in = SEL_W'(i);
            step();
            check_eq($sformatf("fz_chg_ch%0d", i), 32'(out_changed), 32'h0);
            check_eq($sformatf("fz_data_ch%0d", i), 32'(out_data), 32'(pv[i]));
        end
        freeze = 1'b0;

        // 6. Async reset mid-dwell in auto mode
        sel_in = 4'd0;
        step();
        auto_mode = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check_eq("pre_rst_ch", 32'(out_ch), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_ch", 32'(out_ch), 32'h0);
        check_eq("async_rst_data", 32'(out_data), 32'h0);
        check_eq("async_rst_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq($sformatf("restart_k%0d", k), 32'(out_ch), 32'(k / 4));
        end
        auto_mode = 1'b0;
        sel_in    = 4'd1;
        step();
        check_eq("snapshot_lost", 32'(out_changed), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
